// File: rtl/ps2_key_event_filter.sv
// PS/2 scancode-to-key-event filter: resolves E0/F0 prefixes, drops housekeeping
// bytes and typematic repeats, buffers events in a small FIFO, tracks the held key.
module ps2_key_event_filter #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 100000,
  parameter int unsigned SUPPRESS_REPEAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] scancode,
  input  logic       flag,
  output logic [9:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] held_code,
  output logic       held_ext,
  output logic       held_valid,
  output logic       overflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    EXT     = 2'd1,
    BRK     = 2'd2,
    EXT_BRK = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            flag_q;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [9:0]      out_data_q, out_data_d;
  logic            out_valid_q, out_valid_d;
  logic [7:0]      held_code_q, held_code_d;
  logic            held_ext_q, held_ext_d;
  logic            held_valid_q, held_valid_d;
  logic            overflow_q, overflow_d;
  logic [9:0]      mem_q [DEPTH];

  logic            strobe, timeout;
  logic            ev_make, ev_break, ev_ext;
  logic [9:0]      ev_data;
  logic            key_match, suppress, push_req, push_acc, pop, full;

  assign strobe  = flag && !flag_q;
  assign timeout = (state_q != IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign pop     = out_valid_q && out_ready;
  assign full    = (count_q == CW'(DEPTH));

  // Prefix decoding; a byte arriving in the timeout cycle takes priority.
  always_comb begin
    state_d  = state_q;
    ev_make  = 1'b0;
    ev_break = 1'b0;
    ev_ext   = 1'b0;
    if (strobe) begin
      unique case (state_q)
        IDLE: begin
          if (scancode == 8'hE0) begin
            state_d = EXT;
          end else if (scancode == 8'hF0) begin
            state_d = BRK;
          end else if (!(scancode inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFE, 8'hFF})) begin
            ev_make = 1'b1;
          end
        end
        EXT: begin
          if (scancode == 8'hF0) begin
            state_d = EXT_BRK;
          end else if (scancode != 8'hE0) begin
            ev_make = 1'b1;
            ev_ext  = 1'b1;
            state_d = IDLE;
          end
        end
        BRK: begin
          ev_break = 1'b1;
          state_d  = IDLE;
        end
        EXT_BRK: begin
          ev_break = 1'b1;
          ev_ext   = 1'b1;
          state_d  = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end else if (timeout) begin
      state_d = IDLE;
    end
  end

  assign ev_data   = {ev_ext, ev_break, scancode};
  assign key_match = held_valid_q && ({ev_ext, scancode} == {held_ext_q, held_code_q});
  assign suppress  = ev_make && key_match && (SUPPRESS_REPEAT != 0);
  assign push_req  = (ev_make || ev_break) && !suppress;
  assign push_acc  = push_req && (!full || pop);

  // Held key, timeout counter, FIFO bookkeeping and registered head.
  always_comb begin
    held_code_d  = held_code_q;
    held_ext_d   = held_ext_q;
    held_valid_d = held_valid_q;
    tmo_d        = '0;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    out_data_d   = out_data_q;
    overflow_d   = overflow_q;

    if (ev_make && !suppress) begin
      held_code_d  = scancode;
      held_ext_d   = ev_ext;
      held_valid_d = 1'b1;
    end else if (ev_break && key_match) begin
      held_valid_d = 1'b0;
    end

    if (state_q != IDLE && !strobe) begin
      tmo_d = tmo_q + TW'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_acc) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (push_req && full && !pop) begin
      overflow_d = 1'b1;
    end
    count_d = count_q + CW'(push_acc) - CW'(pop);

    // The entry being written this cycle becomes head when the FIFO drains onto it.
    if (push_acc && (rd_ptr_d == wr_ptr_q) && (count_q == CW'(0) || (pop && count_q == CW'(1)))) begin
      out_data_d = ev_data;
    end else if (count_d != CW'(0)) begin
      out_data_d = mem_q[rd_ptr_d];
    end
    out_valid_d = (count_d != CW'(0));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      flag_q       <= 1'b0;
      tmo_q        <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      held_code_q  <= '0;
      held_ext_q   <= 1'b0;
      held_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      flag_q       <= flag;
      tmo_q        <= tmo_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      held_code_q  <= held_code_d;
      held_ext_q   <= held_ext_d;
      held_valid_q <= held_valid_d;
      overflow_q   <= overflow_d;
    end
  end

  // Storage array needs no reset; validity is tracked by count/pointers.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem_q[wr_ptr_q] <= ev_data;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign held_code  = held_code_q;
  assign held_ext   = held_ext_q;
  assign held_valid = held_valid_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_key_event_filter.sv
// Scoreboard bench: two instances (repeat suppression on/off) share stimulus;
// per-instance monitors pop expected events whenever a handshake occurs.
module tb_ps2_key_event_filter;

  localparam int unsigned TMO = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] scancode;
  logic       flag;
  logic       out_ready;
  logic [9:0] out_data_a, out_data_b;
  logic       out_valid_a, out_valid_b;
  logic [7:0] held_code_a, held_code_b;
  logic       held_ext_a, held_ext_b, held_valid_a, held_valid_b;
  logic       overflow_a, overflow_b;

  int n_vec = 0;
  int n_err = 0;
  logic [9:0] qa[$];
  logic [9:0] qb[$];

  always #5 clk = ~clk;

  ps2_key_event_filter #(.DEPTH(4), .TIMEOUT_CYCLES(TMO), .SUPPRESS_REPEAT(1)) u_a (
    .clk(clk), .reset(reset), .scancode(scancode), .flag(flag),
    .out_data(out_data_a), .out_valid(out_valid_a), .out_ready(out_ready),
    .held_code(held_code_a), .held_ext(held_ext_a), .held_valid(held_valid_a),
    .overflow(overflow_a));

  ps2_key_event_filter #(.DEPTH(4), .TIMEOUT_CYCLES(TMO), .SUPPRESS_REPEAT(0)) u_b (
    .clk(clk), .reset(reset), .scancode(scancode), .flag(flag),
    .out_data(out_data_b), .out_valid(out_valid_b), .out_ready(out_ready),
    .held_code(held_code_b), .held_ext(held_ext_b), .held_valid(held_valid_b),
    .overflow(overflow_b));

  function automatic logic [9:0] ev(input logic e, input logic b, input logic [7:0] c);
    return {e, b, c};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitors: compare the head against the scoreboard on every handshake.
  always @(negedge clk) begin
    if (!reset && out_valid_a && out_ready) begin
      n_vec++;
      if (qa.size() == 0) begin
        n_err++;
        $display("FAIL evt_a: got unexpected %0h, expected no event", out_data_a);
      end else begin
        logic [9:0] e;
        e = qa.pop_front();
        if (out_data_a !== e) begin
          n_err++;
          $display("FAIL evt_a: got %0h, expected %0h", out_data_a, e);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && out_valid_b && out_ready) begin
      n_vec++;
      if (qb.size() == 0) begin
        n_err++;
        $display("FAIL evt_b: got unexpected %0h, expected no event", out_data_b);
      end else begin
        logic [9:0] e;
        e = qb.pop_front();
        if (out_data_b !== e) begin
          n_err++;
          $display("FAIL evt_b: got %0h, expected %0h", out_data_b, e);
        end
      end
    end
  end

  task automatic expect_both(input logic [9:0] e);
    qa.push_back(e);
    qb.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    scancode = b;
    flag = 1'b1;
    @(posedge clk); #1;
    flag = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int i = 0; i < 60; i++) begin
      if (qa.size() == 0 && qb.size() == 0) break;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    chk("drain_a", qa.size(), 0);
    chk("drain_b", qb.size(), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    scancode = 8'h00; flag = 1'b0; out_ready = 1'b1;
    do_reset();
    chk("rst_valid", out_valid_a, 0);
    chk("rst_data", out_data_a, 0);
    chk("rst_held", {held_valid_a, held_ext_a, held_code_a}, 0);
    chk("rst_ovf", {overflow_a, overflow_b}, 0);

    // Make then break, with strobe-to-valid latency of one cycle.
    expect_both(ev(0, 0, 8'h1C));
    scancode = 8'h1C; flag = 1'b1;
    chk("lat_pre", out_valid_a, 0);
    @(posedge clk); #1;
    chk("lat_post", out_valid_a, 1);
    flag = 1'b0;
    @(posedge clk); #1;
    chk("held_mk", {held_valid_a, held_code_a}, {1'b1, 8'h1C});
    send(8'hF0);
    expect_both(ev(0, 1, 8'h1C));
    send(8'h1C);
    chk("held_brk", held_valid_a, 0);
    drain();

    // Extended make/break; repeated E0 stays in the extended prefix.
    send(8'hE0);
    expect_both(ev(1, 0, 8'h75));
    send(8'h75);
    chk("held_ext", {held_valid_a, held_ext_a, held_code_a}, {2'b11, 8'h75});
    send(8'hE0);
    send(8'hE0);
    send(8'hF0);
    expect_both(ev(1, 1, 8'h75));
    send(8'h75);
    chk("held_ext_rel", held_valid_a, 0);
    drain();

    // Typematic repeat: A suppresses, B passes every make.
    for (int i = 0; i < 5; i++) begin
      if (i == 0) qa.push_back(ev(0, 0, 8'h1C));
      qb.push_back(ev(0, 0, 8'h1C));
      send(8'h1C);
      drain();
    end
    send(8'hF0);
    expect_both(ev(0, 1, 8'h1C));
    send(8'h1C);
    drain();

    // Housekeeping bytes produce nothing; a long flag pulse is one byte.
    send(8'hAA);
    send(8'hFA);
    send(8'h00);
    drain();
    expect_both(ev(0, 0, 8'h1C));
    scancode = 8'h1C; flag = 1'b1;
    repeat (10) @(posedge clk);
    #1 flag = 1'b0;
    @(posedge clk); #1;
    drain();
    send(8'hF0);
    expect_both(ev(0, 1, 8'h1C));
    send(8'h1C);
    drain();

    // Timeout abandons the break prefix.
    send(8'hF0);
    repeat (TMO + 5) @(posedge clk);
    #1;
    expect_both(ev(0, 0, 8'h2A));
    send(8'h2A);
    chk("tmo_held", {held_valid_a, held_code_a}, {1'b1, 8'h2A});
    drain();

    // FIFO full: fifth event dropped, overflow sticks.
    out_ready = 1'b0;
    chk("ovf_pre", overflow_a, 0);
    expect_both(ev(0, 0, 8'h15)); send(8'h15);
    expect_both(ev(0, 0, 8'h16)); send(8'h16);
    expect_both(ev(0, 0, 8'h1E)); send(8'h1E);
    expect_both(ev(0, 0, 8'h26)); send(8'h26);
    send(8'h25);
    chk("ovf_set", {overflow_a, overflow_b}, 2'b11);
    chk("ovf_held", {held_valid_a, held_code_a}, {1'b1, 8'h25});
    chk("full_head", out_data_a, ev(0, 0, 8'h15));
    // Simultaneous pop and push while full.
    expect_both(ev(0, 0, 8'h2E));
    scancode = 8'h2E; flag = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; flag = 1'b0;
    @(posedge clk); #1;
    chk("ovf_keep", overflow_a, 1);
    chk("pp_head", {out_valid_a, out_data_a}, {1'b1, ev(0, 0, 8'h16)});
    out_ready = 1'b1;
    drain();

    // Reset mid-sequence discards the E0 prefix.
    send(8'hE0);
    do_reset();
    chk("rst2_ovf", {overflow_a, overflow_b}, 0);
    chk("rst2_state", {out_valid_a, out_data_a, held_valid_a}, 0);
    expect_both(ev(0, 0, 8'h1C));
    send(8'h1C);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
